// File: rtl/spiker_pkg.sv
// spiker_pkg: shared feeder state type and default spike vector widths
package spiker_pkg;
    typedef enum logic [0:0] {IDLE, RUN} feeder_state_t;
    localparam int SPK_N_IN  = 4;
    localparam int SPK_N_OUT = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO with wrapping pointers (extra MSB distinguishes full from empty)
// Ports: clk, rst (async), flush (sync clear), push/pop (pre-qualified by the caller),
//        wr_data in; head (entry at read pointer), full, empty, level out.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign level = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = level == (AW+1)'(DEPTH);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/spike_feeder.sv
// spike_feeder: buffers host spike vectors, runs the network sample handshake, counts output spikes
// Ports: clk, rst (async), flush; wr_valid/wr_spikes/wr_ready upstream write;
//        net_ready/net_sample/net_out_spikes from network; net_start/net_sample_ready/
//        net_in_spikes to network; out_cnt, level, busy, underrun status.
module spike_feeder
    import spiker_pkg::*;
#(
    parameter int N_IN  = SPK_N_IN,
    parameter int N_OUT = SPK_N_OUT,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    input  logic [N_IN-1:0]          wr_spikes,
    output logic                     wr_ready,
    input  logic                     net_ready,
    input  logic                     net_sample,
    input  logic [N_OUT-1:0]         net_out_spikes,
    output logic                     net_start,
    output logic                     net_sample_ready,
    output logic [N_IN-1:0]          net_in_spikes,
    output logic [N_OUT*CNT_W-1:0]   out_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     underrun
);
    feeder_state_t                  state, state_nx;
    logic                           seen_busy, full, empty, push, pop, start;
    logic [N_IN-1:0]                head;
    logic [N_OUT-1:0][CNT_W-1:0]    cnt;

    assign wr_ready         = !full;
    assign push             = wr_valid && !full;
    assign busy             = state == RUN;
    assign net_start        = busy;
    assign net_sample_ready = busy && !empty;
    assign pop              = net_sample && net_sample_ready;
    assign net_in_spikes    = empty ? '0 : head;
    assign out_cnt          = cnt;

    sync_fifo #(.WIDTH(N_IN), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
        .wr_data(wr_spikes), .head(head), .full(full), .empty(empty), .level(level)
    );

    // Leaving RUN waits for the network to have gone busy at least once, so an
    // idle net_ready right after start is not mistaken for completion.
    always_comb begin
        state_nx = (state == IDLE) ? ((!empty && net_ready) ? RUN : IDLE)
                                   : ((seen_busy && net_ready && empty) ? IDLE : RUN);
        start    = (state == IDLE) && (state_nx == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            underrun  <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            underrun  <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            seen_busy <= start ? 1'b0 : (seen_busy || (busy && !net_ready));
            underrun  <= underrun || (net_sample && busy && empty);
            if (start) cnt <= '0;
            else if (pop) begin
                for (int i = 0; i < N_OUT; i++)
                    if (net_out_spikes[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spike_feeder.sv
// tb_spike_feeder: directed checks of spike_feeder against a stub network driven by the bench
module tb_spike_feeder;
    logic        clk = 0, rst = 1, flush = 0, wr_valid = 0, net_ready = 0, net_sample = 0;
    logic [3:0]  wr_spikes = 0;
    logic [1:0]  net_out_spikes = 0;
    logic        wr_ready, net_start, net_sample_ready, busy, underrun;
    logic [3:0]  net_in_spikes;
    logic [15:0] out_cnt;
    logic [3:0]  level;
    int          total = 0, bad = 0;

    spike_feeder dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_spikes(wr_spikes),
        .wr_ready(wr_ready), .net_ready(net_ready), .net_sample(net_sample),
        .net_out_spikes(net_out_spikes), .net_start(net_start),
        .net_sample_ready(net_sample_ready), .net_in_spikes(net_in_spikes),
        .out_cnt(out_cnt), .level(level), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"}, net_start, 0);
        chk({tag, "_srdy"}, net_sample_ready, 0);
        chk({tag, "_spk"}, net_in_spikes, 0);
        chk({tag, "_cnt"}, out_cnt, 0);
        chk({tag, "_lvl"}, level, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_urun"}, underrun, 0);
        chk({tag, "_wrdy"}, wr_ready, 1);
    endtask

    task automatic write(input logic [3:0] v);
        wr_valid = 1; wr_spikes = v;
        tick();
        wr_valid = 0;
    endtask

    task automatic enter_run();
        net_ready = 1;
        tick();
        net_ready = 0;
    endtask

    task automatic sample(input string tag, input logic [3:0] exp);
        chk(tag, net_in_spikes, exp);
        net_sample = 1;
        tick();
        net_sample = 0;
    endtask

    initial begin
        logic [3:0] t1 [4];
        t1 = '{4'hF, 4'hE, 4'hD, 4'hC};
        #1;
        chk_reset("rst_in");
        tick(); tick();
        rst = 0;
        tick();
        chk_reset("rst_out");

        // 1: basic run
        for (int i = 0; i < 4; i++) write(t1[i]);
        chk("t1_lvl", level, 4);
        chk("t1_head_idle", net_in_spikes, 4'hF);
        chk("t1_start_idle", net_start, 0);
        net_sample = 1;
        tick();
        net_sample = 0;
        chk("t1_idle_sample_lvl", level, 4);
        chk("t1_idle_sample_urun", underrun, 0);
        enter_run();
        chk("t1_start", net_start, 1);
        chk("t1_busy", busy, 1);
        chk("t1_srdy", net_sample_ready, 1);
        net_out_spikes = 2'b01;
        for (int i = 0; i < 4; i++) sample($sformatf("t1_spk%0d", i), t1[i]);
        net_out_spikes = 0;
        chk("t1_srdy_empty", net_sample_ready, 0);
        chk("t1_spk_empty", net_in_spikes, 0);
        chk("t1_cnt", out_cnt, 16'h0004);
        chk("t1_busy_hold", busy, 1);
        net_ready = 1;
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_start_drop", net_start, 0);
        net_ready = 0;

        // 2: full FIFO
        for (int i = 0; i < 8; i++) write(4'(i + 1));
        chk("t2_lvl", level, 8);
        wr_valid = 1; wr_spikes = 4'hA;
        tick();
        chk("t2_wrdy", wr_ready, 0);
        chk("t2_lvl_full", level, 8);
        net_ready = 1;
        tick();
        net_ready = 0;
        chk("t2_busy", busy, 1);
        chk("t2_head", net_in_spikes, 1);
        net_sample = 1;
        tick();
        net_sample = 0;
        chk("t2_lvl_pop", level, 7);
        chk("t2_wrdy_pop", wr_ready, 1);
        tick();
        wr_valid = 0;
        chk("t2_lvl_a", level, 8);
        for (int i = 0; i < 7; i++) sample($sformatf("t2_spk%0d", i), 4'(i + 2));
        sample("t2_spk_a", 4'hA);
        chk("t2_lvl_end", level, 0);
        net_ready = 1;
        tick();
        net_ready = 0;
        chk("t2_idle", busy, 0);

        // 3: underrun and flush
        write(4'h5);
        enter_run();
        net_out_spikes = 2'b10;
        sample("t3_spk", 4'h5);
        chk("t3_cnt", out_cnt, 16'h0100);
        sample("t3_spk_empty", 4'h0);
        net_out_spikes = 0;
        chk("t3_urun", underrun, 1);
        chk("t3_lvl", level, 0);
        chk("t3_cnt_hold", out_cnt, 16'h0100);
        flush = 1;
        tick();
        flush = 0;
        chk_reset("t3_flush");

        // 4: saturation with continuous push+pop
        write(4'h3);
        enter_run();
        wr_valid = 1; wr_spikes = 4'h3; net_sample = 1; net_out_spikes = 2'b11;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 99) begin
                chk("t4_cnt100", out_cnt, 16'h6464);
                chk("t4_lvl100", level, 1);
            end
        end
        wr_valid = 0; net_sample = 0; net_out_spikes = 0;
        chk("t4_cnt_sat", out_cnt, 16'hFFFF);
        flush = 1;
        tick();
        flush = 0;
        chk("t4_flush_lvl", level, 0);

        // 5: simultaneous push and pop at level 3
        for (int i = 1; i <= 3; i++) write(4'(i));
        enter_run();
        chk("t5_lvl", level, 3);
        wr_valid = 1; wr_spikes = 4'h4; net_sample = 1;
        tick();
        wr_valid = 0; net_sample = 0;
        chk("t5_lvl_same", level, 3);
        for (int i = 2; i <= 4; i++) sample($sformatf("t5_spk%0d", i), 4'(i));

        // 6: async reset mid-run
        for (int i = 0; i < 5; i++) write(4'(i + 7));
        chk("t6_lvl", level, 5);
        chk("t6_busy", busy, 1);
        #3;
        rst = 1;
        #1;
        chk_reset("t6_rst");
        tick();
        rst = 0;
        net_ready = 1;
        tick();
        chk("t6_no_run", busy, 0);
        write(4'h9);
        chk("t6_lvl_new", level, 1);
        tick();
        chk("t6_run", busy, 1);
        chk("t6_head", net_in_spikes, 4'h9);
        net_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
